// File: rtl/clk_ref_stamper_pkg.sv
// -----------------------------------------------------------------------------
// clk_ref_stamper_pkg
// Shared definitions for the reference-clock stamper and the readout FIFO that
// consumes its records.
//   DEFAULT_WIDTH    : total count/stamp width
//   DEFAULT_LOW_W    : width of the fast-incrementing low part of the count
//   DEFAULT_CHANNELS : number of hit inputs
//   ch_width()       : channel-index width for a given channel count (min 1)
//   record_width()   : width of a packed record {channel, overflow, stamp}
//                      channel in the MSBs, then overflow, stamp in the LSBs
// -----------------------------------------------------------------------------
package clk_ref_stamper_pkg;

    localparam int DEFAULT_WIDTH    = 48;
    localparam int DEFAULT_LOW_W    = 24;
    localparam int DEFAULT_CHANNELS = 4;

    // Channel-index width, never narrower than one bit.
    function automatic int ch_width(input int channels);
        if (channels > 1) begin
            return $clog2(channels);
        end else begin
            return 1;
        end
    endfunction

    // Packed record width: channel index, overflow flag, stamp.
    function automatic int record_width(input int width, input int channels);
        return ch_width(channels) + 1 + width;
    endfunction

endpackage

// File: rtl/clk_ref_stamper_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter over CHANNELS requesters. The pointer names the channel
// with highest priority; after a grant to channel k it moves to k+1 mod
// CHANNELS. Grant is combinational so the consumer can load and free a slot in
// the same cycle it is granted.
//   clk         : clock
//   reset       : synchronous active-high reset (pointer -> channel 0)
//   req         : request vector
//   advance     : the current grant was consumed this cycle
//   grant       : one-hot grant (all zero when nothing requests)
//   grant_idx   : index of the granted channel
//   grant_valid : at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter
    import clk_ref_stamper_pkg::*;
#(
    parameter  int CHANNELS = DEFAULT_CHANNELS,
    localparam int CH_W     = ch_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic [CHANNELS-1:0] grant,
    output logic [CH_W-1:0]     grant_idx,
    output logic                grant_valid
);

    logic [CH_W-1:0] ptr_r;
    logic [CH_W-1:0] idx_s;
    int              best_rank_s;
    int              rank_s;

    // Pick the requester with the smallest distance from the pointer.
    always_comb begin
        idx_s       = {CH_W{1'b0}};
        best_rank_s = CHANNELS;
        rank_s      = 0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (c >= int'(ptr_r)) begin
                rank_s = c - int'(ptr_r);
            end else begin
                rank_s = c + CHANNELS - int'(ptr_r);
            end
            if (req[c] && (rank_s < best_rank_s)) begin
                best_rank_s = rank_s;
                idx_s       = CH_W'(c);
            end else begin
                best_rank_s = best_rank_s;
            end
        end
    end

    // Expand the chosen index into the one-hot grant.
    always_comb begin
        grant = {CHANNELS{1'b0}};
        if (|req) begin
            grant[idx_s] = 1'b1;
        end else begin
            grant = {CHANNELS{1'b0}};
        end
    end

    assign grant_idx   = idx_s;
    assign grant_valid = |req;

    // Priority pointer: one past the last consumed grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= {CH_W{1'b0}};
        end else if (advance) begin
            if (idx_s == CH_W'(CHANNELS - 1)) begin
                ptr_r <= {CH_W{1'b0}};
            end else begin
                ptr_r <= idx_s + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_ref_stamper.sv
// -----------------------------------------------------------------------------
// clk_ref_stamper
// Counts pre-detected reference-clock rising edges into a WIDTH-bit count made
// of a low part and a one-cycle-delayed high part, timestamps per-channel hit
// pulses against that count and drains the stamps round-robin onto a single
// valid/ready stream.
//   sampling_clk  : sole clock
//   reset_falling : synchronous active-high reset
//   clk_in_rising : one-cycle pulse per reference-clock rising edge
//   hit           : per-channel one-cycle hit pulses
//   ref_count     : count value captured at the last clk_in_rising
//   out_valid     : stamp record available
//   out_ready     : downstream accepts the record
//   out_channel   : channel of the record
//   out_stamp     : coherent count at the hit cycle
//   out_overflow  : a later hit on this channel was dropped while it waited
//   dropped       : sticky per-channel drop flags
// -----------------------------------------------------------------------------
module clk_ref_stamper
    import clk_ref_stamper_pkg::*;
#(
    parameter  int WIDTH    = DEFAULT_WIDTH,
    parameter  int LOW_W    = DEFAULT_LOW_W,
    parameter  int CHANNELS = DEFAULT_CHANNELS,
    localparam int CH_W     = ch_width(CHANNELS)
) (
    input  logic                sampling_clk,
    input  logic                reset_falling,
    input  logic                clk_in_rising,
    input  logic [CHANNELS-1:0] hit,
    output logic [WIDTH-1:0]    ref_count,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CH_W-1:0]     out_channel,
    output logic [WIDTH-1:0]    out_stamp,
    output logic                out_overflow,
    output logic [CHANNELS-1:0] dropped
);

    localparam int HIGH_W = WIDTH - LOW_W;
    localparam int REC_W  = record_width(WIDTH, CHANNELS);

    // Count state
    logic [LOW_W-1:0]    low_r;
    logic [HIGH_W-1:0]   high_r;
    logic [HIGH_W-1:0]   high_p1_r;
    logic                carry_pending_r;
    logic                wrap_s;
    logic [WIDTH-1:0]    cur_s;

    // Slot state
    logic [CHANNELS-1:0] slot_full_r;
    logic [CHANNELS-1:0] slot_ovf_r;
    logic [WIDTH-1:0]    slot_stamp_r [CHANNELS];

    // Arbitration / output
    logic [CHANNELS-1:0] grant_s;
    logic [CH_W-1:0]     grant_idx_s;
    logic                grant_valid_s;
    logic                load_s;
    logic [CHANNELS-1:0] free_s;
    logic [REC_W-1:0]    out_rec_r;
    logic                out_valid_r;

    assign wrap_s = clk_in_rising && (&low_r);

    // While the carry is in flight high_p1 already holds the post-carry value,
    // so the coherent count never needs a wide adder on the capture path.
    assign cur_s = {(carry_pending_r ? high_p1_r : high_r), low_r};

    // Low/high counter with one-cycle carry pipeline and ref capture.
    always_ff @(posedge sampling_clk) begin
        if (reset_falling) begin
            low_r           <= {LOW_W{1'b0}};
            high_r          <= {HIGH_W{1'b0}};
            high_p1_r       <= HIGH_W'(1'b1);
            carry_pending_r <= 1'b0;
            ref_count       <= {WIDTH{1'b0}};
        end else begin
            if (clk_in_rising) begin
                low_r     <= low_r + 1'b1;
                ref_count <= cur_s;
            end
            // A wrap cannot coincide with a pending carry since LOW_W >= 2.
            carry_pending_r <= wrap_s;
            if (carry_pending_r) begin
                high_r    <= high_p1_r;
                high_p1_r <= high_p1_r + 1'b1;
            end
        end
    end

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_rr_arbiter (
        .clk         (sampling_clk),
        .reset       (reset_falling),
        .req         (slot_full_r),
        .advance     (load_s),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // The output register takes a new record when empty or when handing over.
    assign load_s = grant_valid_s && (!out_valid_r || out_ready);
    assign free_s = grant_s & {CHANNELS{load_s}};

    // Per-channel slots: load on hit when empty or being freed, else drop.
    always_ff @(posedge sampling_clk) begin
        if (reset_falling) begin
            slot_full_r <= {CHANNELS{1'b0}};
            slot_ovf_r  <= {CHANNELS{1'b0}};
            dropped     <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                slot_stamp_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (hit[i] && (!slot_full_r[i] || free_s[i])) begin
                    slot_full_r[i]  <= 1'b1;
                    slot_stamp_r[i] <= cur_s;
                    slot_ovf_r[i]   <= 1'b0;
                end else if (hit[i]) begin
                    slot_ovf_r[i] <= 1'b1;
                    dropped[i]    <= 1'b1;
                end else if (free_s[i]) begin
                    slot_full_r[i] <= 1'b0;
                end
            end
        end
    end

    // Output record register; holds stable while stalled.
    always_ff @(posedge sampling_clk) begin
        if (reset_falling) begin
            out_valid_r <= 1'b0;
            out_rec_r   <= {REC_W{1'b0}};
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_rec_r   <= {grant_idx_s, slot_ovf_r[grant_idx_s], slot_stamp_r[grant_idx_s]};
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid    = out_valid_r;
    assign out_stamp    = out_rec_r[WIDTH-1:0];
    assign out_overflow = out_rec_r[WIDTH];
    assign out_channel  = out_rec_r[REC_W-1:WIDTH+1];

endmodule

// File: tb/tb_clk_ref_stamper.sv
module tb_clk_ref_stamper;

    localparam int W  = 8;
    localparam int LW = 4;
    localparam int NC = 4;
    localparam int CW = 2;

    logic          sampling_clk = 1'b0;
    logic          reset_falling;
    logic          clk_in_rising;
    logic [NC-1:0] hit;
    logic [W-1:0]  ref_count;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_channel;
    logic [W-1:0]  out_stamp;
    logic          out_overflow;
    logic [NC-1:0] dropped;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic          ovf;
        logic [W-1:0]  stamp;
    } rec_t;

    typedef struct {
        int          npulse;
        int          ch;
        logic        rise_on_hit;
        logic [W-1:0] exp_stamp;
        logic [W-1:0] exp_ref;
    } vec_t;

    rec_t sb_q[$];
    rec_t exp_rec;
    int   checks = 0;
    int   errors = 0;
    bit   sb_en  = 1'b1;
    bit   seen_valid;
    vec_t vecs[7];

    clk_ref_stamper #(
        .WIDTH    (W),
        .LOW_W    (LW),
        .CHANNELS (NC)
    ) dut (
        .sampling_clk  (sampling_clk),
        .reset_falling (reset_falling),
        .clk_in_rising (clk_in_rising),
        .hit           (hit),
        .ref_count     (ref_count),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_channel   (out_channel),
        .out_stamp     (out_stamp),
        .out_overflow  (out_overflow),
        .dropped       (dropped)
    );

    always #5 sampling_clk = ~sampling_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every transferred record must match the head of the queue.
    always @(negedge sampling_clk) begin
        if (sb_en && !reset_falling && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got ch%0d stamp 0x%0h ovf %0d, expected none",
                         out_channel, out_stamp, out_overflow);
            end else begin
                exp_rec = sb_q.pop_front();
                check("rec_channel",  32'(out_channel),  32'(exp_rec.ch));
                check("rec_stamp",    32'(out_stamp),    32'(exp_rec.stamp));
                check("rec_overflow", 32'(out_overflow), 32'(exp_rec.ovf));
            end
        end
    end

    // One cycle of stimulus; called and returns at #1 after a rising edge.
    task automatic step(input logic rise, input logic [NC-1:0] h);
        clk_in_rising = rise;
        hit           = h;
        @(posedge sampling_clk);
        #1;
        clk_in_rising = 1'b0;
        hit           = '0;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 4'b0000);
    endtask

    task automatic do_reset();
        reset_falling = 1'b1;
        clk_in_rising = 1'b0;
        hit           = '0;
        @(posedge sampling_clk);
        #1;
        reset_falling = 1'b0;
        sb_q.delete();
    endtask

    task automatic push(input int ch, input logic ovf, input logic [W-1:0] stamp);
        rec_t r;
        r.ch    = CW'(ch);
        r.ovf   = ovf;
        r.stamp = stamp;
        sb_q.push_back(r);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 64 && (sb_q.size() != 0 || out_valid); i++) begin
            @(posedge sampling_clk);
            #1;
        end
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        // {npulse before, channel, rise with hit, expected stamp, expected ref}
        vecs[0] = '{3,   1, 1'b0, 8'h03, 8'h02};
        vecs[1] = '{2,   3, 1'b0, 8'h05, 8'h04};
        vecs[2] = '{11,  2, 1'b0, 8'h10, 8'h0F};
        vecs[3] = '{0,   0, 1'b0, 8'h10, 8'h0F};
        vecs[4] = '{240, 1, 1'b0, 8'h00, 8'hFF};
        vecs[5] = '{1,   2, 1'b0, 8'h01, 8'h00};
        vecs[6] = '{0,   3, 1'b1, 8'h01, 8'h01};

        reset_falling = 1'b1;
        clk_in_rising = 1'b0;
        hit           = '0;
        out_ready     = 1'b1;
        @(posedge sampling_clk);
        @(posedge sampling_clk);
        #1;
        reset_falling = 1'b0;

        // Reset state
        check("rst_ref",      32'(ref_count),    32'd0);
        check("rst_valid",    32'(out_valid),    32'd0);
        check("rst_channel",  32'(out_channel),  32'd0);
        check("rst_stamp",    32'(out_stamp),    32'd0);
        check("rst_overflow", 32'(out_overflow), 32'd0);
        check("rst_dropped",  32'(dropped),      32'd0);

        // Wrap and carry cycle
        pulses(15);
        check("wrap_ref15", 32'(ref_count), 32'h0E);
        step(1'b1, 4'b0000);
        check("wrap_ref16", 32'(ref_count), 32'h0F);
        push(0, 1'b0, 8'h10);
        step(1'b1, 4'b0001);
        check("carry_ref17", 32'(ref_count), 32'h10);
        check("carry_lat1", 32'(out_valid), 32'd0);
        step(1'b1, 4'b0000);
        check("carry_ref18", 32'(ref_count), 32'h11);
        drain("carry_drain");

        // Table-driven single hits
        do_reset();
        out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            pulses(vecs[v].npulse);
            push(vecs[v].ch, 1'b0, vecs[v].exp_stamp);
            step(vecs[v].rise_on_hit, 4'b0001 << vecs[v].ch);
            drain("vec_drain");
            check("vec_ref", 32'(ref_count), 32'(vecs[v].exp_ref));
        end

        // Simultaneous hits at count 5
        do_reset();
        pulses(5);
        for (int c = 0; c < NC; c++) push(c, 1'b0, 8'h05);
        step(1'b0, 4'b1111);
        check("simul_lat1", 32'(out_valid), 32'd0);
        for (int k = 0; k < NC; k++) begin
            @(posedge sampling_clk);
            #1;
            check("simul_valid", 32'(out_valid),   32'd1);
            check("simul_order", 32'(out_channel), 32'(k));
        end
        @(posedge sampling_clk);
        #1;
        check("simul_idle", 32'(out_valid), 32'd0);
        check("simul_queue", 32'(sb_q.size()), 32'd0);

        // Backpressure with overflow
        do_reset();
        out_ready = 1'b0;
        pulses(3);
        step(1'b0, 4'b0010);
        pulses(1);
        step(1'b0, 4'b0010);
        pulses(2);
        step(1'b0, 4'b0010);
        check("bp_dropped", 32'(dropped), 32'b0010);
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_valid", 32'(out_valid),    32'd1);
            check("bp_hold_ch",    32'(out_channel),  32'd1);
            check("bp_hold_stamp", 32'(out_stamp),    32'h03);
            check("bp_hold_ovf",   32'(out_overflow), 32'd0);
            @(posedge sampling_clk);
            #1;
        end
        push(1, 1'b0, 8'h03);
        push(1, 1'b1, 8'h04);
        out_ready = 1'b1;
        drain("bp_drain");
        check("bp_dropped_sticky", 32'(dropped), 32'b0010);

        // Fairness between ch0 and ch2
        do_reset();
        sb_en = 1'b0;
        hit   = 4'b0101;
        @(posedge sampling_clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            @(posedge sampling_clk);
            #1;
            check("fair_valid", 32'(out_valid),   32'd1);
            check("fair_ch",    32'(out_channel), (k % 2 == 0) ? 32'd0 : 32'd2);
            check("fair_stamp", 32'(out_stamp),   32'd0);
        end
        hit = '0;
        do_reset();
        sb_en = 1'b1;

        // Reset mid-stream
        out_ready = 1'b0;
        pulses(3);
        step(1'b0, 4'b1111);
        step(1'b0, 4'b1111);
        check("mid_pre_valid",   32'(out_valid), 32'd1);
        check("mid_pre_dropped", 32'(dropped),   32'b1110);
        reset_falling = 1'b1;
        hit           = 4'b1111;
        clk_in_rising = 1'b1;
        out_ready     = 1'b1;
        @(posedge sampling_clk);
        #1;
        reset_falling = 1'b0;
        hit           = '0;
        clk_in_rising = 1'b0;
        sb_q.delete();
        check("mid_ref",      32'(ref_count),    32'd0);
        check("mid_valid",    32'(out_valid),    32'd0);
        check("mid_channel",  32'(out_channel),  32'd0);
        check("mid_stamp",    32'(out_stamp),    32'd0);
        check("mid_overflow", 32'(out_overflow), 32'd0);
        check("mid_dropped",  32'(dropped),      32'd0);
        seen_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge sampling_clk);
            #1;
            seen_valid = seen_valid | out_valid;
        end
        check("mid_no_stale", 32'(seen_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_ref_stamper.md
# clk_ref_stamper

Parametrised successor to the reference-clock counter. It counts rising edges of the external reference clock (`clk_in_rising`, pre-detected) into a WIDTH-bit coherent count split into a low part and a pipelined high part. It timestamps hit pulses on CHANNELS inputs against that count and drains the stamps, round-robin, onto a single valid/ready stream. It sits between the edge detectors and the readout FIFO, in the `sampling_clk` domain.

## Interface
Parameters:
- `WIDTH`, 48, total count/stamp width.
- `LOW_W`, 24, low-part width; `HIGH_W = WIDTH-LOW_W`; requires 2 ≤ LOW_W < WIDTH.
- `CHANNELS`, 4, number of hit inputs (≥1).
- `CH_W`, `$clog2(CHANNELS)` (min 1), derived channel-index width.

Ports (one clock; reset is synchronous and active-high):
- `sampling_clk`  in  1  sole clock.
- `reset_falling`  in  1  synchronous active-high reset.
- `clk_in_rising`  in  1  one-cycle pulse per reference-clock rising edge.
- `hit`  in  CHANNELS  per-channel one-cycle hit pulses.
- `ref`  out  WIDTH  count value captured at the last `clk_in_rising`.
- `out_valid`  out  1  stamp record available.
- `out_ready`  in  1  downstream accepts the record.
- `out_channel`  out  CH_W  channel of the record.
- `out_stamp`  out  WIDTH  coherent count at the hit cycle.
- `out_overflow`  out  1  at least one later hit on this channel was dropped while this record waited.
- `dropped`  out  CHANNELS  sticky per-channel drop flags.

## Operation
- Counter: `low` +1 on `clk_in_rising`. On a wrap (all ones → 0), set `carry_pending`. In the next cycle, `high` +1 and `carry_pending` clears, unconditionally, including when `clk_in_rising` is also high (low still increments).
- `high_p1` is a register that always holds `high+1`. The coherent count is `cur = {carry_pending ? high_p1 : high, low}`; no wide adder sits on the capture path.
- `ref <= cur` (pre-increment value) on `clk_in_rising`; it holds otherwise.
- Slots: one per channel, holding `full`, `stamp`, and `ovf`.
  - `hit[i]` in cycle t on an empty slot, or on a slot being freed in cycle t: load `stamp = cur(t)`, set `full`, clear `ovf`.
  - `hit[i]` on a full slot that is not being freed: keep the old stamp, set `ovf` and `dropped[i]`.
- Arbiter: round-robin over full slots. After reset the highest priority is channel 0. After a grant to channel k, it is channel k+1 mod CHANNELS.
- Output register:
  - Loads the granted slot when empty or when the current record transfers (`out_valid && out_ready`). The granted slot is freed in the same cycle.
  - While `out_valid && !out_ready`, all output fields hold stable.
- `dropped` clears only on reset.
- Reset: `low`, `high`, `carry_pending`, `ref`, all slots, the arbiter pointer, `out_valid`, `out_channel`, `out_stamp`, `out_overflow`, and `dropped` go to 0, and `high_p1` goes to 1. Reset overrides every concurrent input, and a pending record is discarded.

## Timing
- A carry reaches `high` 1 cycle after the wrap edge. `cur` is coherent in every cycle.
- Hit latency: hit in cycle t → slot full at t+1 → `out_valid` at t+2 if the output register is free and the channel wins the grant.
- Throughput: 1 record per cycle with `out_ready` held high.
- `ref` updates 1 cycle after `clk_in_rising`.

## Structure
- Shared package/header: `WIDTH`, `LOW_W`, and the record layout `{channel, overflow, stamp}`, also used by the readout FIFO.
- Sub-module `rr_arbiter` (parameter CHANNELS): inputs request vector and advance strobe; outputs one-hot grant and index. The counter, slots, and output register stay in the top level.

## Test plan
All scenarios use WIDTH=8, LOW_W=4, CHANNELS=4 unless noted.
- Wrap: 16 `clk_in_rising` pulses from reset. The 16th gives `ref`=0x0F. The next cycle `high`=1, and the 17th pulse gives `ref`=0x10.
- Carry cycle: a hit on ch0 the cycle after the 16th pulse gives `out_stamp`=0x10. A `clk_in_rising` in that same carry cycle gives count 0x11 with no lost carry.
- Simultaneous hits: all four channels hit at count 0x05 with `out_ready`=1. Expect records ch0, ch1, ch2, ch3 on four consecutive cycles starting at t+2, all with stamp 0x05 and overflow 0.
- Backpressure:
  - `out_ready`=0; hit ch1 at count 3, then ch1 at count 4, then ch1 at count 6. The first record is held stable; the second ch1 record stays queued in its slot.
  - The count-6 hit is dropped, setting `dropped[1]`=1 and the slot's `ovf`.
  - After `out_ready`=1: records ch1/0x03/overflow 0, then ch1/0x04/overflow 1. `dropped` stays 0b0010.
- Fairness: continuous hits on ch0 and ch2 with `out_ready`=1 give records alternating 0, 2, 0, 2.
- Reset mid-stream: assert `reset_falling` while `out_valid`=1 and slots are full. The next cycle all outputs are 0, and no stale record appears afterwards.
